// File: rtl/ex_mem_reg_if.sv
// ---------------------------------------------------------------------------
// ex_mem_reg_if -- signal bundle between the EX stage, the EX/MEM register
// and the MEM stage.
//
// Parameters:
//   DATA_W  width of ALU result, store data, PC and immediate
//   REG_W   width of the destination register index
//
// Upstream (EX -> register):
//   in_valid, in_ready, alu_res, alu_zero, rt_data, dest_reg, pc_plus4,
//   imm_ext, branch, mem_read, mem_write, reg_write, mem_to_reg, flush
// Downstream (register -> MEM):
//   out_valid, out_ready, out_alu_res, out_rt_data, out_dest_reg,
//   out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
//   br_taken, br_target
//
// Modports:
//   master  surrounding pipeline: drives upstream entries and out_ready
//   slave   the EX/MEM register itself
// ---------------------------------------------------------------------------
interface ex_mem_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic [DATA_W-1:0] rt_data;
  logic [REG_W-1:0]  dest_reg;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] imm_ext;
  logic              branch;
  logic              mem_read;
  logic              mem_write;
  logic              reg_write;
  logic              mem_to_reg;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_rt_data;
  logic [REG_W-1:0]  out_dest_reg;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;

  modport master (
    output in_valid, alu_res, alu_zero, rt_data, dest_reg, pc_plus4, imm_ext,
           branch, mem_read, mem_write, reg_write, mem_to_reg, flush, out_ready,
    input  in_ready, out_valid, out_alu_res, out_rt_data, out_dest_reg,
           out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
           br_taken, br_target
  );

  modport slave (
    input  in_valid, alu_res, alu_zero, rt_data, dest_reg, pc_plus4, imm_ext,
           branch, mem_read, mem_write, reg_write, mem_to_reg, flush, out_ready,
    output in_ready, out_valid, out_alu_res, out_rt_data, out_dest_reg,
           out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
           br_taken, br_target
  );
endinterface

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg -- EX/MEM pipeline register built as a two-entry skid buffer
// (head + skid) with valid/ready handshakes on both sides. The branch
// decision and branch target are computed on capture and stored with the
// entry.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ex_mem_reg_if.slave: upstream entry, flush, downstream entry
//
// Optional feature (macro EXMEM_BR_SQUASH_EN): popping a head entry whose
// branch is taken also discards the skid entry and any entry accepted in the
// same cycle. Without the macro, wrong-path entries are removed only by flush.
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_mem_reg_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] rt_data;
    logic [REG_W-1:0]  dest_reg;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;
  } entry_t;

  entry_t r_head, r_skid;
  entry_t w_head_next, w_skid_next, w_new;
  logic   r_head_valid, r_skid_valid, r_in_ready;
  logic   w_head_valid_next, w_skid_valid_next;
  logic   w_accept, w_pop, w_squash;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_pop    = r_head_valid & bus.out_ready;

`ifdef EXMEM_BR_SQUASH_EN
  assign w_squash = w_pop & r_head.br_taken;
`else
  assign w_squash = 1'b0;
`endif

  // Entry as captured from the EX stage; the target wraps silently.
  always_comb begin
    w_new            = '0;
    w_new.alu_res    = bus.alu_res;
    w_new.rt_data    = bus.rt_data;
    w_new.dest_reg   = bus.dest_reg;
    w_new.mem_read   = bus.mem_read;
    w_new.mem_write  = bus.mem_write;
    w_new.reg_write  = bus.reg_write;
    w_new.mem_to_reg = bus.mem_to_reg;
    w_new.br_taken   = bus.branch & bus.alu_zero;
    w_new.br_target  = bus.pc_plus4 + {bus.imm_ext[DATA_W-3:0], 2'b00};
  end

  // Skid is only ever occupied while head is, so "head empty" implies
  // "skid empty" and the cases below are exhaustive.
  always_comb begin
    w_head_next       = r_head;
    w_skid_next       = r_skid;
    w_head_valid_next = r_head_valid;
    w_skid_valid_next = r_skid_valid;
    if (bus.flush || w_squash) begin
      w_head_valid_next = 1'b0;
      w_skid_valid_next = 1'b0;
    end else if (!r_head_valid) begin
      if (w_accept) begin
        w_head_next       = w_new;
        w_head_valid_next = 1'b1;
      end
    end else if (!w_pop) begin
      if (w_accept) begin
        w_skid_next       = w_new;
        w_skid_valid_next = 1'b1;
      end
    end else if (r_skid_valid) begin
      // in_ready is low here, so no accept can coincide with this move.
      w_head_next       = r_skid;
      w_skid_valid_next = 1'b0;
    end else if (w_accept) begin
      w_head_next = w_new;
    end else begin
      w_head_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head       <= '0;
      r_skid       <= '0;
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_head       <= w_head_next;
      r_skid       <= w_skid_next;
      r_head_valid <= w_head_valid_next;
      r_skid_valid <= w_skid_valid_next;
      r_in_ready   <= ~w_skid_valid_next;
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = r_head_valid;
  assign bus.out_alu_res    = r_head.alu_res;
  assign bus.out_rt_data    = r_head.rt_data;
  assign bus.out_dest_reg   = r_head.dest_reg;
  assign bus.out_mem_to_reg = r_head.mem_to_reg;
  assign bus.br_target      = r_head.br_target;
  // Side-effecting controls are masked so an empty stage can never act.
  assign bus.out_mem_read   = r_head.mem_read  & r_head_valid;
  assign bus.out_mem_write  = r_head.mem_write & r_head_valid;
  assign bus.out_reg_write  = r_head.reg_write & r_head_valid;
  assign bus.br_taken       = r_head.br_taken  & r_head_valid;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ex_mem_reg_if #(.DATA_W(32), .REG_W(5)) bus ();

  ex_mem_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the register behaves as an in-order FIFO of depth 2.
  typedef struct {
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  dest;
    logic        mr, mw, rw, m2r, bt;
    logic [31:0] tgt;
  } ent_t;

  ent_t mq[$];

  task automatic put(input logic v, input logic [31:0] alu, input logic [31:0] pc,
                     input logic [31:0] imm, input logic br, input logic z,
                     input logic mw);
    bus.in_valid   = v;
    bus.alu_res    = alu;
    bus.alu_zero   = z;
    bus.rt_data    = alu ^ 32'hA5A5_A5A5;
    bus.dest_reg   = alu[4:0];
    bus.pc_plus4   = pc;
    bus.imm_ext    = imm;
    bus.branch     = br;
    bus.mem_read   = 1'b0;
    bus.mem_write  = mw;
    bus.reg_write  = 1'b1;
    bus.mem_to_reg = 1'b0;
  endtask

  // Advance the model with the inputs present at the coming edge, then
  // clock the DUT and settle 1 time unit past the edge.
  task automatic tick();
    bit   acc, pop, squash;
    ent_t e;
    acc    = bus.in_valid && (mq.size() < 2);
    pop    = (mq.size() > 0) && bus.out_ready;
    squash = 1'b0;
    e.alu  = bus.alu_res;
    e.rt   = bus.rt_data;
    e.dest = bus.dest_reg;
    e.mr   = bus.mem_read;
    e.mw   = bus.mem_write;
    e.rw   = bus.reg_write;
    e.m2r  = bus.mem_to_reg;
    e.bt   = bus.branch && bus.alu_zero;
    e.tgt  = bus.pc_plus4 + bus.imm_ext * 32'd4;
`ifdef EXMEM_BR_SQUASH_EN
    if (pop && mq[0].bt) squash = 1'b1;
`endif
    if (bus.flush || squash) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++;
    if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL rst_br_taken got=%b exp=0", bus.br_taken); end
    checks++;
    // Fill both entries, then reset asynchronously in mid-cycle.
    bus.out_ready = 1'b0;
    put(1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    tick();
    put(1'b1, 32'h12, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_pre_full got=%b exp=0", bus.in_ready); end
    checks++;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    bus.flush = 1'b1;
    #1;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%b exp=1", bus.in_ready); end
    checks++;
    if (bus.out_mem_write !== 1'b0 || bus.br_taken !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_ctrl got mw=%b bt=%b exp=0/0", bus.out_mem_write, bus.br_taken);
    end
    checks++;
    mq.delete();
    bus.flush = 1'b0;
    #1 rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    put(1'b1, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    checks++;
    if (bus.out_alu_res !== 32'h0000_0010) begin failures++; $display("FAIL single_alu got=%h exp=00000010", bus.out_alu_res); end
    checks++;
    bus.in_valid = 1'b0;
    tick();
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", bus.out_valid); end
    checks++;
    $display("test_single done");
  endtask

  task automatic test_order();
    bus.out_ready = 1'b0;
    put(1'b1, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL order_ready_a got=%b exp=1", bus.in_ready); end
    checks++;
    put(1'b1, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL order_ready_b got=%b exp=0", bus.in_ready); end
    checks++;
    put(1'b1, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);  // refused: in_ready=0
    tick();
    if (bus.out_alu_res !== 32'd1 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL order_hold got=%h v=%b exp=1 v=1", bus.out_alu_res, bus.out_valid);
    end
    checks++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    if (bus.out_alu_res !== 32'd2 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL order_second got=%h v=%b exp=2 v=1", bus.out_alu_res, bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL order_ready_c got=%b exp=1", bus.in_ready); end
    checks++;
    tick();
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL order_drain got=%b exp=0", bus.out_valid); end
    checks++;
    $display("test_order done");
  endtask

  task automatic test_branch();
    bus.out_ready = 1'b0;
    put(1'b1, 32'h40, 32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    tick();
    if (bus.br_taken !== 1'b1) begin failures++; $display("FAIL branch_taken got=%b exp=1", bus.br_taken); end
    checks++;
    if (bus.br_target !== 32'h0000_00FC) begin failures++; $display("FAIL branch_target got=%h exp=000000fc", bus.br_target); end
    checks++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL branch_gated got=%b exp=0", bus.br_taken); end
    checks++;
    $display("test_branch done");
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b0;
    put(1'b1, 32'h41, 32'hFFFF_FFFC, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    tick();
    if (bus.br_target !== 32'h0000_0004) begin failures++; $display("FAIL wrap_target got=%h exp=00000004", bus.br_target); end
    checks++;
    if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL wrap_not_taken got=%b exp=0", bus.br_taken); end
    checks++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    $display("test_wrap done");
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    put(1'b1, 32'h51, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    put(1'b1, 32'h52, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", bus.in_ready); end
    checks++;
    put(1'b1, 32'h53, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready); end
    checks++;
    if (bus.out_mem_write !== 1'b0) begin failures++; $display("FAIL flush_mw got=%b exp=0", bus.out_mem_write); end
    checks++;
    $display("test_flush done");
  endtask

  task automatic test_squash();
    bus.out_ready = 1'b0;
    put(1'b1, 32'h61, 32'h100, 32'h4, 1'b1, 1'b1, 1'b0);
    tick();
    put(1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
`ifdef EXMEM_BR_SQUASH_EN
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL squash_valid got=%b exp=0", bus.out_valid); end
    checks++;
`else
    if (bus.out_valid !== 1'b1 || bus.out_alu_res !== 32'h55) begin
      failures++; $display("FAIL squash_skid got v=%b alu=%h exp v=1 alu=00000055", bus.out_valid, bus.out_alu_res);
    end
    checks++;
    tick();
`endif
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL squash_ready got=%b exp=1", bus.in_ready); end
    checks++;
    $display("test_squash done");
  endtask

  task automatic test_random();
    int fails_before;
    fails_before = failures;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.flush      = ($urandom_range(0, 24) == 0);
      bus.alu_res    = $urandom;
      bus.rt_data    = $urandom;
      bus.dest_reg   = 5'($urandom);
      bus.pc_plus4   = $urandom;
      bus.imm_ext    = $urandom;
      bus.alu_zero   = 1'($urandom);
      bus.branch     = ($urandom_range(0, 7) == 0);
      bus.mem_read   = 1'($urandom);
      bus.mem_write  = 1'($urandom);
      bus.reg_write  = 1'($urandom);
      bus.mem_to_reg = 1'($urandom);
      tick();
      if (bus.out_valid !== (mq.size() > 0)) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, mq.size() > 0);
      end
      checks++;
      if (bus.in_ready !== (mq.size() < 2)) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, mq.size() < 2);
      end
      checks++;
      if (mq.size() > 0) begin
        if (bus.out_alu_res !== mq[0].alu || bus.out_rt_data !== mq[0].rt || bus.out_dest_reg !== mq[0].dest) begin
          failures++;
          $display("FAIL rnd_data cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, bus.out_alu_res, bus.out_rt_data,
                   bus.out_dest_reg, mq[0].alu, mq[0].rt, mq[0].dest);
        end
        checks++;
        if ({bus.out_mem_read, bus.out_mem_write, bus.out_reg_write, bus.out_mem_to_reg, bus.br_taken} !==
            {mq[0].mr, mq[0].mw, mq[0].rw, mq[0].m2r, mq[0].bt}) begin
          failures++;
          $display("FAIL rnd_ctrl cyc=%0d got=%b%b%b%b%b exp=%b%b%b%b%b", cyc, bus.out_mem_read, bus.out_mem_write,
                   bus.out_reg_write, bus.out_mem_to_reg, bus.br_taken, mq[0].mr, mq[0].mw, mq[0].rw, mq[0].m2r, mq[0].bt);
        end
        checks++;
        if (bus.br_target !== mq[0].tgt) begin
          failures++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", cyc, bus.br_target, mq[0].tgt);
        end
        checks++;
      end else begin
        if ({bus.out_mem_read, bus.out_mem_write, bus.out_reg_write, bus.br_taken} !== 4'b0000) begin
          failures++;
          $display("FAIL rnd_gated cyc=%0d got=%b%b%b%b exp=0000", cyc, bus.out_mem_read, bus.out_mem_write,
                   bus.out_reg_write, bus.br_taken);
        end
        checks++;
      end
    end
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    $display("test_random done: %0d new failures", failures - fails_before);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    put(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single();
    test_order();
    test_branch();
    test_wrap();
    test_flush();
    test_squash();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
